// File: rtl/sd_data_pkg.sv
// Shared definitions for the SD host DATA path: FSM state encoding,
// CRC-status token values and the CRC16 generator polynomial.
package sd_data_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      DATA,
      CRC,
      END,
      STAT_WAIT,
      STAT,
      BUSY,
      DONE
   } state_t;

   // CRC-status token returned by the card after a written block
   localparam logic [2:0] TOKEN_ACCEPTED  = 3'b010;
   localparam logic [2:0] TOKEN_CRC_ERR   = 3'b101;
   localparam logic [2:0] TOKEN_WRITE_ERR = 3'b110;

   // x^16 + x^12 + x^5 + 1
   localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0), one bit per enabled cycle.
// Shared by the DATA transmit and receive paths.
module sd_crc16 import sd_data_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic fb;

   assign fb = bit_in ^ crc[15];

   // LFSR update; clear has priority so a new block always starts from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= '0;
      end else if (clr) begin
         crc <= '0;
      end else if (en) begin
         crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/sd_data_tx_phy.sv
// SD DAT0 write path: serializes one block (start, data MSB-first, CRC16,
// end), releases the line and decodes the CRC-status token and busy period.
// Optional feature macro: SD_DATA_TX_BUSY_TIMEOUT_EN (busy-phase timeout).
//
// Handshake with the data controller: Serial_ready is high only in IDLE; a
// Send seen in IDLE starts exactly one block; Complete pulses for one cycle
// when the block ends, with Crc_error/Timeout valid alongside it and held
// until the next start; Idle aborts from any state without a Complete.
module sd_data_tx_phy import sd_data_pkg::*; #(
   parameter int BLOCK_WORDS   = 128,
   parameter int STATUS_WINDOW = 8
) (
   input  logic        SD_clock,
   input  logic        Reset_n,
   input  logic        Send,
   input  logic        Idle,
   input  logic [31:0] Data_from_FIFO,
   output logic        Read_FIFO,
   input  logic        Data_pin_in,
   output logic        Data_pin_out,
   output logic        Data_oe,
   input  logic        Timeout_enable,
   input  logic [15:0] Timeout_reg,
   output logic        Serial_ready,
   output logic        Complete,
   output logic        Crc_error,
   output logic        Timeout,
   output state_t      dbg_state
);

   localparam logic [12:0] LAST_BIT = 13'(32 * BLOCK_WORDS - 1);
   localparam logic [12:0] LAST_WIN = 13'(STATUS_WINDOW - 1);

   state_t      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [31:0] sreg_q, sreg_d;
   logic [2:0]  tok_q, tok_d;
   logic        pin_d, oe_d, complete_d, crc_err_d, timeout_d;
   logic        crc_clr, crc_en, crc_bit;
   logic [15:0] crc_val;
   logic        word_end;

`ifdef SD_DATA_TX_BUSY_TIMEOUT_EN
   logic [15:0] busy_cnt_q, busy_cnt_d;
`else
   logic        unused_timeout_cfg;
   assign unused_timeout_cfg = ^{Timeout_enable, Timeout_reg};
`endif

   sd_crc16 u_crc (
      .clk    (SD_clock),
      .rst_n  (Reset_n),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (crc_bit),
      .crc    (crc_val)
   );

   // Last bit of a word that is not the final word of the block
   assign word_end     = (cnt_q[4:0] == 5'd31) && (cnt_q != LAST_BIT);
   // Pops coincide with the word capture; an abort suppresses the pop
   assign Read_FIFO    = !Idle && ((state_q == START) || ((state_q == DATA) && word_end));
   assign Serial_ready = (state_q == IDLE);
   assign dbg_state    = state_q;

   // Next-state and next-output decode; line outputs are registered from here
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sreg_d     = sreg_q;
      tok_d      = tok_q;
      pin_d      = Data_pin_out;
      oe_d       = Data_oe;
      complete_d = 1'b0;
      crc_err_d  = Crc_error;
      timeout_d  = Timeout;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      crc_bit    = 1'b0;
`ifdef SD_DATA_TX_BUSY_TIMEOUT_EN
      busy_cnt_d = busy_cnt_q;
`endif
      if (Idle && (state_q != IDLE)) begin
         state_d = IDLE;
         pin_d   = 1'b1;
         oe_d    = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               pin_d = 1'b1;
               oe_d  = 1'b0;
               if (Send && !Idle) begin
                  state_d   = START;
                  pin_d     = 1'b0;
                  oe_d      = 1'b1;
                  cnt_d     = '0;
                  crc_clr   = 1'b1;
                  crc_err_d = 1'b0;
                  timeout_d = 1'b0;
               end
            end
            START: begin
               state_d = DATA;
               cnt_d   = '0;
               pin_d   = Data_from_FIFO[31];
               sreg_d  = {Data_from_FIFO[30:0], 1'b0};
               crc_en  = 1'b1;
               crc_bit = Data_from_FIFO[31];
            end
            DATA: begin
               if (cnt_q == LAST_BIT) begin
                  state_d = CRC;
                  cnt_d   = '0;
                  pin_d   = crc_val[15];
               end else begin
                  cnt_d = cnt_q + 13'd1;
                  if (word_end) begin
                     pin_d  = Data_from_FIFO[31];
                     sreg_d = {Data_from_FIFO[30:0], 1'b0};
                  end else begin
                     pin_d  = sreg_q[31];
                     sreg_d = {sreg_q[30:0], 1'b0};
                  end
                  crc_en  = 1'b1;
                  crc_bit = pin_d;
               end
            end
            CRC: begin
               if (cnt_q[3:0] == 4'd15) begin
                  state_d = END;
                  cnt_d   = '0;
                  pin_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 13'd1;
                  pin_d = crc_val[4'd14 - cnt_q[3:0]];
               end
            end
            END: begin
               state_d = STAT_WAIT;
               cnt_d   = '0;
               pin_d   = 1'b1;
               oe_d    = 1'b0;
            end
            STAT_WAIT: begin
               if (!Data_pin_in) begin
                  state_d = STAT;
                  cnt_d   = '0;
               end else if (cnt_q == LAST_WIN) begin
                  state_d    = DONE;
                  timeout_d  = 1'b1;
                  complete_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 13'd1;
               end
            end
            STAT: begin
               // three token bits, then the token end bit whose value is ignored
               if (cnt_q == 13'd3) begin
                  state_d   = BUSY;
                  cnt_d     = '0;
                  crc_err_d = (tok_q != TOKEN_ACCEPTED);
`ifdef SD_DATA_TX_BUSY_TIMEOUT_EN
                  busy_cnt_d = '0;
`endif
               end else begin
                  cnt_d = cnt_q + 13'd1;
                  tok_d = {tok_q[1:0], Data_pin_in};
               end
            end
            BUSY: begin
               if (Data_pin_in) begin
                  state_d    = DONE;
                  complete_d = 1'b1;
               end
`ifdef SD_DATA_TX_BUSY_TIMEOUT_EN
               else if (Timeout_enable &&
                        (({1'b0, busy_cnt_q} + 17'd1) >= {1'b0, Timeout_reg})) begin
                  state_d    = DONE;
                  complete_d = 1'b1;
                  timeout_d  = 1'b1;
               end else begin
                  busy_cnt_d = busy_cnt_q + 16'd1;
               end
`endif
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               pin_d   = 1'b1;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   // State, datapath and registered line/status outputs
   always_ff @(posedge SD_clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sreg_q       <= '0;
         tok_q        <= '0;
         Data_pin_out <= 1'b1;
         Data_oe      <= 1'b0;
         Complete     <= 1'b0;
         Crc_error    <= 1'b0;
         Timeout      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sreg_q       <= sreg_d;
         tok_q        <= tok_d;
         Data_pin_out <= pin_d;
         Data_oe      <= oe_d;
         Complete     <= complete_d;
         Crc_error    <= crc_err_d;
         Timeout      <= timeout_d;
      end
   end

`ifdef SD_DATA_TX_BUSY_TIMEOUT_EN
   // Cycles spent in BUSY, restarted on every entry
   always_ff @(posedge SD_clock or negedge Reset_n) begin
      if (!Reset_n) begin
         busy_cnt_q <= '0;
      end else begin
         busy_cnt_q <= busy_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_sd_data_tx_phy.sv
// Directed bench for sd_data_tx_phy with BLOCK_WORDS=2, STATUS_WINDOW=8.
// Honors SD_DATA_TX_BUSY_TIMEOUT_EN when it is defined for the build.
module tb_sd_data_tx_phy;
   import sd_data_pkg::*;

   localparam int W    = 2;
   localparam int SW   = 8;
   localparam int BASE = 32 * W + 18;   // first status-window index

   logic        SD_clock = 1'b0;
   logic        Reset_n  = 1'b0;
   logic        Send = 1'b0;
   logic        Idle = 1'b0;
   logic [31:0] Data_from_FIFO;
   logic        Read_FIFO;
   logic        Data_pin_in = 1'b1;
   logic        Data_pin_out;
   logic        Data_oe;
   logic        Timeout_enable = 1'b0;
   logic [15:0] Timeout_reg = 16'd0;
   logic        Serial_ready;
   logic        Complete;
   logic        Crc_error;
   logic        Timeout;
   state_t      dbg_state;

   int checks = 0;
   int errors = 0;

   // FIFO model (first-word-fall-through)
   logic [31:0] fifo_mem [0:255];
   logic [7:0]  rd_ptr = 8'd0;
   logic [7:0]  p0;
   assign Data_from_FIFO = fifo_mem[rd_ptr];

   // expected DAT0 stream
   logic [0:0] exp_q[$];

   // observations from one transfer
   logic obs_pin [0:511];
   logic obs_oe  [0:511];
   logic obs_rd  [0:511];
   logic obs_sr  [0:511];
   int   obs_n;
   int   obs_cidx;
   logic obs_cerr, obs_to;

   // card script
   int       st_idx;
   logic [2:0] card_tok;
   int       card_busy;

   sd_data_tx_phy #(.BLOCK_WORDS(W), .STATUS_WINDOW(SW)) dut (
      .SD_clock       (SD_clock),
      .Reset_n        (Reset_n),
      .Send           (Send),
      .Idle           (Idle),
      .Data_from_FIFO (Data_from_FIFO),
      .Read_FIFO      (Read_FIFO),
      .Data_pin_in    (Data_pin_in),
      .Data_pin_out   (Data_pin_out),
      .Data_oe        (Data_oe),
      .Timeout_enable (Timeout_enable),
      .Timeout_reg    (Timeout_reg),
      .Serial_ready   (Serial_ready),
      .Complete       (Complete),
      .Crc_error      (Crc_error),
      .Timeout        (Timeout),
      .dbg_state      (dbg_state)
   );

   // clock
   always #5 SD_clock = ~SD_clock;

   // FIFO pop
   always @(posedge SD_clock) begin
      if (Read_FIFO === 1'b1) rd_ptr <= rd_ptr + 8'd1;
   end

   // reference CRC16 over the n low bits of d, MSB first
   function automatic logic [15:0] crc_model(input logic [63:0] d, input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = n - 1; i >= 0; i--) begin
         fb = d[i] ^ c[15];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   // card-driven DAT0 level for cycle index i
   function automatic logic card_level(input int i);
      logic [2:0] t;
      t = card_tok;
      if (st_idx < 0 || i < st_idx) return 1'b1;
      if (i == st_idx) return 1'b0;
      if (i <= st_idx + 3) return t[3 - (i - st_idx)];
      if (i == st_idx + 4) return 1'b1;
      if (card_busy < 0 || i <= st_idx + 4 + card_busy) return 1'b0;
      return 1'b1;
   endfunction

   task automatic load_fifo(input logic [31:0] w0, input logic [31:0] w1);
      fifo_mem[rd_ptr]           = w0;
      fifo_mem[8'(rd_ptr + 8'd1)] = w1;
      p0 = rd_ptr;
   endtask

   task automatic build_expected(input logic [31:0] w0, input logic [31:0] w1);
      logic [63:0] d;
      logic [15:0] c;
      d = {w0, w1};
      c = crc_model(d, 64);
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 63; i >= 0; i--) exp_q.push_back(d[i]);
      for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
      exp_q.push_back(1'b1);
   endtask

   // issue Send and record outputs per cycle index until Complete or limit
   task automatic run_block(input int limit);
      Send = 1'b1;
      @(negedge SD_clock);
      Send     = 1'b0;
      obs_cidx = -1;
      obs_n    = 0;
      obs_cerr = 1'bx;
      obs_to   = 1'bx;
      for (int i = 0; i < limit; i++) begin
         obs_pin[i] = Data_pin_out;
         obs_oe[i]  = Data_oe;
         obs_rd[i]  = Read_FIFO;
         obs_sr[i]  = Serial_ready;
         obs_n      = i + 1;
         if (Complete === 1'b1) begin
            obs_cidx = i;
            obs_cerr = Crc_error;
            obs_to   = Timeout;
            break;
         end
         Data_pin_in = card_level(i);
         @(negedge SD_clock);
      end
      Data_pin_in = 1'b1;
      @(negedge SD_clock);
   endtask

   task automatic test_reset;
      Reset_n = 1'b0;
      repeat (2) @(negedge SD_clock);
      checks++; if (Data_pin_out !== 1'b1) begin errors++; $display("FAIL reset_pin: got %b want 1", Data_pin_out); end
      checks++; if (Data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", Data_oe); end
      checks++; if (Read_FIFO !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", Read_FIFO); end
      checks++; if (Serial_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", Serial_ready); end
      checks++; if (Complete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b want 0", Complete); end
      checks++; if (Crc_error !== 1'b0) begin errors++; $display("FAIL reset_crc_error: got %b want 0", Crc_error); end
      checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", Timeout); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
      Reset_n = 1'b1;
      @(negedge SD_clock);
   endtask

   task automatic test_zero_block;
      load_fifo(32'h0000_0000, 32'h0000_0000);
      build_expected(32'h0000_0000, 32'h0000_0000);
      st_idx = BASE; card_tok = TOKEN_ACCEPTED; card_busy = 3;
      run_block(300);
      for (int i = 0; i < 32 * W + 18; i++) begin
         logic [0:0] e;
         e = exp_q.pop_front();
         checks++;
         if (i >= obs_n || obs_pin[i] !== e[0]) begin
            errors++; $display("FAIL zero_stream[%0d]: got %b want %b", i, obs_pin[i], e[0]);
         end
      end
      checks++; if (obs_cidx !== BASE + 9) begin errors++; $display("FAIL zero_complete_idx: got %0d want %0d", obs_cidx, BASE + 9); end
      checks++; if (obs_cerr !== 1'b0) begin errors++; $display("FAIL zero_crc_error: got %b want 0", obs_cerr); end
      checks++; if (obs_to !== 1'b0) begin errors++; $display("FAIL zero_timeout: got %b want 0", obs_to); end
      checks++; if (8'(rd_ptr - p0) !== 8'd2) begin errors++; $display("FAIL zero_pops: got %0d want 2", 8'(rd_ptr - p0)); end
      checks++; if (obs_sr[5] !== 1'b0) begin errors++; $display("FAIL zero_ready_busy: got %b want 0", obs_sr[5]); end
      checks++; if (Serial_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_after: got %b want 1", Serial_ready); end
   endtask

   task automatic test_pattern;
      load_fifo(32'hA5A5_0F0F, 32'h1234_5678);
      build_expected(32'hA5A5_0F0F, 32'h1234_5678);
      st_idx = BASE + 2; card_tok = TOKEN_ACCEPTED; card_busy = 0;
      run_block(300);
      for (int i = 0; i < 32 * W + 18; i++) begin
         logic [0:0] e;
         e = exp_q.pop_front();
         checks++;
         if (i >= obs_n || obs_pin[i] !== e[0]) begin
            errors++; $display("FAIL pattern_stream[%0d]: got %b want %b", i, obs_pin[i], e[0]);
         end
      end
      for (int i = 0; i <= 32 * W + 18; i++) begin
         checks++;
         if (obs_oe[i] !== (i <= 32 * W + 17)) begin
            errors++; $display("FAIL pattern_oe[%0d]: got %b want %b", i, obs_oe[i], (i <= 32 * W + 17));
         end
      end
      for (int i = 0; i < obs_n; i++) begin
         checks++;
         if (obs_rd[i] !== (i == 0 || i == 32)) begin
            errors++; $display("FAIL pattern_read_fifo[%0d]: got %b want %b", i, obs_rd[i], (i == 0 || i == 32));
         end
      end
      checks++; if (obs_cidx !== BASE + 8) begin errors++; $display("FAIL pattern_complete_idx: got %0d want %0d", obs_cidx, BASE + 8); end
      checks++; if (obs_cerr !== 1'b0) begin errors++; $display("FAIL pattern_crc_error: got %b want 0", obs_cerr); end
   endtask

   task automatic test_crc_token;
      load_fifo(32'hDEAD_BEEF, 32'h0102_0304);
      st_idx = BASE + SW - 1; card_tok = TOKEN_CRC_ERR; card_busy = 1;
      run_block(300);
      checks++; if (obs_cidx !== BASE + SW - 1 + 7) begin errors++; $display("FAIL token_complete_idx: got %0d want %0d", obs_cidx, BASE + SW + 6); end
      checks++; if (obs_cerr !== 1'b1) begin errors++; $display("FAIL token_crc_error: got %b want 1", obs_cerr); end
      checks++; if (obs_to !== 1'b0) begin errors++; $display("FAIL token_timeout: got %b want 0", obs_to); end
      repeat (3) @(negedge SD_clock);
      checks++; if (Crc_error !== 1'b1) begin errors++; $display("FAIL token_crc_error_hold: got %b want 1", Crc_error); end
   endtask

   task automatic test_window_timeout;
      load_fifo(32'h8000_0001, 32'hFFFF_FFFF);
      st_idx = -1; card_tok = TOKEN_ACCEPTED; card_busy = 0;
      run_block(300);
      checks++; if (obs_cidx !== BASE + SW) begin errors++; $display("FAIL window_complete_idx: got %0d want %0d", obs_cidx, BASE + SW); end
      checks++; if (obs_to !== 1'b1) begin errors++; $display("FAIL window_timeout: got %b want 1", obs_to); end
      checks++; if (obs_cerr !== 1'b0) begin errors++; $display("FAIL window_crc_error: got %b want 0", obs_cerr); end
   endtask

   task automatic test_busy_timeout;
      load_fifo(32'h0F0F_F0F0, 32'h5555_AAAA);
      Timeout_enable = 1'b1;
      Timeout_reg    = 16'd20;
      st_idx = BASE; card_tok = TOKEN_ACCEPTED;
`ifdef SD_DATA_TX_BUSY_TIMEOUT_EN
      card_busy = -1;
      run_block(400);
      checks++; if (obs_cidx !== BASE + 25) begin errors++; $display("FAIL busy_complete_idx: got %0d want %0d", obs_cidx, BASE + 25); end
      checks++; if (obs_to !== 1'b1) begin errors++; $display("FAIL busy_timeout: got %b want 1", obs_to); end
`else
      card_busy = 100;
      run_block(400);
      checks++; if (obs_cidx !== BASE + 106) begin errors++; $display("FAIL busy_complete_idx: got %0d want %0d", obs_cidx, BASE + 106); end
      checks++; if (obs_to !== 1'b0) begin errors++; $display("FAIL busy_timeout: got %b want 0", obs_to); end
`endif
      checks++; if (obs_cerr !== 1'b0) begin errors++; $display("FAIL busy_crc_error: got %b want 0", obs_cerr); end
      Timeout_enable = 1'b0;
      Timeout_reg    = 16'd0;
   endtask

   task automatic test_abort;
      logic seen;
      load_fifo(32'h1111_2222, 32'h3333_4444);
      Send = 1'b1;
      @(negedge SD_clock);
      Send = 1'b0;
      repeat (32) @(negedge SD_clock);
      checks++; if (Read_FIFO !== 1'b1) begin errors++; $display("FAIL abort_pre_read: got %b want 1", Read_FIFO); end
      Idle = 1'b1;
      #1;
      checks++; if (Read_FIFO !== 1'b0) begin errors++; $display("FAIL abort_read_gated: got %b want 0", Read_FIFO); end
      @(negedge SD_clock);
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL abort_state: got %0d want %0d", dbg_state, IDLE); end
      checks++; if (Data_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b want 0", Data_oe); end
      checks++; if (Data_pin_out !== 1'b1) begin errors++; $display("FAIL abort_pin: got %b want 1", Data_pin_out); end
      Idle = 1'b0;
      seen = 1'b0;
      repeat (120) begin
         @(negedge SD_clock);
         if (Complete !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_complete: got %b want 0", seen); end
      checks++; if (8'(rd_ptr - p0) !== 8'd1) begin errors++; $display("FAIL abort_pops: got %0d want 1", 8'(rd_ptr - p0)); end
      // Idle wins over Send in IDLE
      Idle = 1'b1;
      Send = 1'b1;
      @(negedge SD_clock);
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL idle_beats_send: got %0d want %0d", dbg_state, IDLE); end
      Idle = 1'b0;
      Send = 1'b0;
      @(negedge SD_clock);
   endtask

   task automatic test_reset_mid;
      load_fifo(32'hCAFE_F00D, 32'h7777_8888);
      Send = 1'b1;
      @(negedge SD_clock);
      Send = 1'b0;
      repeat (32) @(negedge SD_clock);
      #2 Reset_n = 1'b0;
      #1;
      checks++; if (Data_pin_out !== 1'b1) begin errors++; $display("FAIL rst_mid_pin: got %b want 1", Data_pin_out); end
      checks++; if (Data_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b want 0", Data_oe); end
      checks++; if (Read_FIFO !== 1'b0) begin errors++; $display("FAIL rst_mid_rd: got %b want 0", Read_FIFO); end
      checks++; if (Serial_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", Serial_ready); end
      checks++; if (Complete !== 1'b0) begin errors++; $display("FAIL rst_mid_complete: got %b want 0", Complete); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, IDLE); end
      @(negedge SD_clock);
      Reset_n = 1'b1;
      @(negedge SD_clock);
      checks++; if (8'(rd_ptr - p0) !== 8'd1) begin errors++; $display("FAIL rst_mid_pops: got %0d want 1", 8'(rd_ptr - p0)); end
   endtask

   // test sequence and final report
   initial begin
      for (int i = 0; i < 256; i++) fifo_mem[i] = 32'h0;
      test_reset();
      test_zero_block();
      test_pattern();
      test_crc_token();
      test_window_timeout();
      test_busy_timeout();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
